cpu_trace_checker: RTL and testbench
====================================

# cpu_trace_checker

Parametrised, streaming checker for single-character CPU write-back trace messages. One ASCII character arrives per clock. The block classifies each complete message as a register write, a memory write or invalid, and flags semantic errors in the time, PC, address and register fields. It sits on the trace-capture path behind the UART/char feeder and generalises the fixed-format `cpu_checker`:

- field widths and legal ranges are parameters;
- it re-synchronises on `^` mid-message;
- it keeps a saturating count of valid messages.

## Interface
Parameters:
- TIME_DIGITS, 4, max decimal digits in time field (min 1)
- PC_DIGITS, 8, exact hex digits in PC field
- ADDR_DIGITS, 8, exact hex digits in memory-address field
- DATA_DIGITS, 8, exact hex digits in data field
- REG_DIGITS, 4, max decimal digits in register field (min 1)
- REG_COUNT, 32, legal register numbers 0..REG_COUNT-1
- PC_LO / PC_HI, 32'h3000 / 32'h4fff, inclusive legal PC range
- ADDR_LO / ADDR_HI, 32'h0 / 32'h2fff, inclusive legal address range
- CNT_W, 16, width of msg_count

Ports:
- clk  in  1  clock
- reset  in  1  reset; one clock; reset is synchronous and active-high
- char  in  8  ASCII character, sampled every rising edge
- freq  in  16  clock-frequency value; even, >= 2; sampled at `#`
- format_type  out  2  0 none/invalid, 1 register write, 2 memory write
- error_code  out  4  bit0 time, bit1 PC, bit2 addr, bit3 reg; 0 when format_type = 0
- msg_count  out  CNT_W  number of messages with format_type != 0, saturating

## Operation
- Grammar: `^` TIME `@` PC `:` SP* body SP* `<=` SP* DATA SP* `#`.
  - body is `$` REG or `*` ADDR.
  - TIME and REG are 1..max decimal digits.
  - PC, ADDR and DATA are exact-count hex digits; upper and lower case are both accepted.
  - `<=` must be contiguous.
- FSM states: IDLE, TIME, PC, COLON_SP, REG, ADDR, PRE_LT, EQ, PRE_DATA, DATA, POST_DATA.
- Each state keeps a digit counter. An overflowing digit count or an illegal character sends the FSM to IDLE.
- `^` in any state clears accumulators and enters TIME. This is the resync behaviour.
- Accumulators:
  - time: ×10 + d, width ceil(log2(10^TIME_DIGITS)).
  - reg: same rule with REG_DIGITS.
  - pc/addr: shift left 4 | nibble, 4·digits wide.
  - Data is checked for count only.
- On `#` in POST_DATA, or in DATA with the count complete:
  - Emit format_type 1 (`$`) or 2 (`*`).
  - Set error bits:
    - bit0: time % (freq>>1) != 0.
    - bit1: PC outside [PC_LO, PC_HI] or PC[1:0] != 0.
    - bit2: memory message only; addr outside [ADDR_LO, ADDR_HI] or addr[1:0] != 0.
    - bit3: register message only; reg >= REG_COUNT.
- `#` anywhere else emits nothing, and the FSM goes to IDLE.

## Timing
- Reset values: state IDLE, format_type 0, error_code 0, msg_count 0, accumulators 0.
- format_type and error_code are registered.
  - They are nonzero only in the cycle after the edge that samples the terminating `#` (1-cycle latency, 1-cycle pulse).
  - They return to 0 the next edge, unless that edge also completes a message. It cannot, because at least 2 further chars are required.
- msg_count increments on the same edge the pulse is launched. It holds at 2^CNT_W-1.
- A `^` sampled on the same edge as a pulse is legal and starts the next message. Back-to-back messages need no idle gap.
- reset asserted mid-message: the partial message is discarded, and the first message after deassertion is parsed normally.
- freq changes take effect at the next sampled `#`. Only freq at the `#` edge matters.

## Structure
- Package `cpu_trace_pkg`:
  - FSM state enum;
  - format codes FMT_NONE/FMT_REG/FMT_MEM;
  - error bit indices ERR_TIME/ERR_PC/ERR_ADDR/ERR_REG.
- Sub-module `ascii_classify` (combinational): char → is_dec, is_hex, nibble value, is_space.
- Top module: FSM, accumulators, error evaluation, counter.

## Test plan
- freq=2, "^242@000030f4: $31 <=12345678#" → format_type 1 and error_code 0 one cycle after `#`; msg_count 1.
- "^338@00003130: *00000088 <= Ffffb528#" → format_type 2, error_code 0.
- Invalid messages, each → format_type stays 0 and msg_count unchanged:
  - "…<=#" (no data);
  - "…<=1232158998#" (10 data digits);
  - " ab" before data.
- freq=4 with time 243 → bit0; "$32" → bit3; PC 00005000 → bit1; addr 00003000 → bit2. Each gives error_code with only the corresponding bit set.
- "^24^242@000030f4: $31 <=12345678#" → single valid pulse (resync).
- reset pulsed after "^242@0000" then a full valid message → exactly one pulse and msg_count 1. Also: CNT_W=2 with 5 valid messages → msg_count 3.

Source files
------------

// File: rtl/cpu_trace_checker_pkg.sv
// Shared types and constants for the CPU write-back trace checker.
// Holds the parser state encoding, output codes and the field-width helper.
package cpu_trace_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TIME,
        ST_PC,
        ST_COLON_SP,
        ST_REG,
        ST_ADDR,
        ST_PRE_LT,
        ST_EQ,
        ST_PRE_DATA,
        ST_DATA,
        ST_POST_DATA
    } state_e;

    localparam logic [1:0] FMT_NONE = 2'd0;
    localparam logic [1:0] FMT_REG  = 2'd1;
    localparam logic [1:0] FMT_MEM  = 2'd2;

    localparam int ERR_TIME = 0;
    localparam int ERR_PC   = 1;
    localparam int ERR_ADDR = 2;
    localparam int ERR_REG  = 3;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LT     = 8'h3C;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_HASH   = 8'h23;

    // Bits needed to hold any decimal number of up to 'digits' digits: ceil(log2(10^digits)).
    function automatic int dec_width(input int digits);
        longint unsigned lim;
        int w;
        lim = 1;
        w   = 0;
        for (int i = 0; i < digits; i++) begin
            lim = lim * 10;
        end
        for (int b = 63; b >= 1; b--) begin
            if ((64'd1 << b) >= lim) begin
                w = b;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/cpu_trace_checker_ascii_classify.sv
// Combinational ASCII classifier: decimal digit, hex digit (either case), space,
// and the 4-bit value of the digit when it is one.
module ascii_classify (
    input  logic [7:0] char_i,
    output logic       is_dec_o,
    output logic       is_hex_o,
    output logic       is_space_o,
    output logic [3:0] nibble_o
);

    logic is_lower_af;
    logic is_upper_af;

    always_comb begin
        is_dec_o    = (char_i >= 8'h30) && (char_i <= 8'h39);
        is_lower_af = (char_i >= 8'h61) && (char_i <= 8'h66);
        is_upper_af = (char_i >= 8'h41) && (char_i <= 8'h46);
        is_hex_o    = is_dec_o || is_lower_af || is_upper_af;
        is_space_o  = (char_i == 8'h20);
        nibble_o    = 4'h0;
        if (is_dec_o) begin
            nibble_o = char_i[3:0];
        end else if (is_lower_af || is_upper_af) begin
            // 'a'/'A' have low nibble 1, so +9 maps a..f onto 10..15.
            nibble_o = char_i[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/cpu_trace_checker.sv
// Streaming checker for one-char-per-clock CPU write-back trace messages:
// classifies each message and flags time/PC/address/register field errors.
module cpu_trace_checker
    import cpu_trace_pkg::*;
#(
    parameter int          TIME_DIGITS = 4,
    parameter int          PC_DIGITS   = 8,
    parameter int          ADDR_DIGITS = 8,
    parameter int          DATA_DIGITS = 8,
    parameter int          REG_DIGITS  = 4,
    parameter int          REG_COUNT   = 32,
    parameter logic [31:0] PC_LO       = 32'h3000,
    parameter logic [31:0] PC_HI       = 32'h4fff,
    parameter logic [31:0] ADDR_LO     = 32'h0,
    parameter logic [31:0] ADDR_HI     = 32'h2fff,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic [15:0]      freq,
    output logic [1:0]       format_type,
    output logic [3:0]       error_code,
    output logic [CNT_W-1:0] msg_count
);

    localparam int TW = dec_width(TIME_DIGITS);
    localparam int RW = dec_width(REG_DIGITS);
    localparam int PW = 4 * PC_DIGITS;
    localparam int AW = 4 * ADDR_DIGITS;
    localparam int CW = 8;
    localparam int MW = (TW > 16) ? TW : 16;

    logic       is_dec;
    logic       is_hex;
    logic       is_space;
    logic [3:0] nibble;

    ascii_classify u_classify (
        .char_i     (char),
        .is_dec_o   (is_dec),
        .is_hex_o   (is_hex),
        .is_space_o (is_space),
        .nibble_o   (nibble)
    );

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [TW-1:0]    time_q;
    logic [TW-1:0]    time_d;
    logic [RW-1:0]    reg_q;
    logic [RW-1:0]    reg_d;
    logic [PW-1:0]    pc_q;
    logic [PW-1:0]    pc_d;
    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    addr_d;
    logic             is_mem_q;
    logic [1:0]       fmt_q;
    logic [3:0]       err_q;
    logic [CNT_W-1:0] msg_cnt_q;

    logic [CW-1:0] cnt_inc;
    logic          time_room;
    logic          pc_room;
    logic          reg_room;
    logic          addr_room;
    logic          data_room;
    logic          msg_done;
    logic [MW-1:0] half_freq;
    logic [3:0]    err_vec;

    assign time_d  = (time_q * TW'(10)) + TW'(nibble);
    assign reg_d   = (reg_q * RW'(10)) + RW'(nibble);
    assign pc_d    = (pc_q << 4) | PW'(nibble);
    assign addr_d  = (addr_q << 4) | AW'(nibble);
    assign cnt_inc = cnt_q + CW'(1);

    assign time_room = cnt_q < CW'(TIME_DIGITS);
    assign pc_room   = cnt_q < CW'(PC_DIGITS);
    assign reg_room  = cnt_q < CW'(REG_DIGITS);
    assign addr_room = cnt_q < CW'(ADDR_DIGITS);
    assign data_room = cnt_q < CW'(DATA_DIGITS);

    // A message completes on '#' after trailing spaces, or directly after the last data digit.
    assign msg_done = (char == CH_HASH) &&
                      ((state_q == ST_POST_DATA) ||
                       ((state_q == ST_DATA) && (cnt_q == CW'(DATA_DIGITS))));

    assign half_freq = MW'(freq >> 1);

    always_comb begin
        err_vec = 4'b0000;
        err_vec[ERR_TIME] = (half_freq != '0) && ((MW'(time_q) % half_freq) != '0);
        err_vec[ERR_PC]   = (64'(pc_q) < 64'(PC_LO)) || (64'(pc_q) > 64'(PC_HI)) ||
                            (pc_q[1:0] != 2'b00);
        err_vec[ERR_ADDR] = is_mem_q &&
                            ((64'(addr_q) < 64'(ADDR_LO)) || (64'(addr_q) > 64'(ADDR_HI)) ||
                             (addr_q[1:0] != 2'b00));
        err_vec[ERR_REG]  = !is_mem_q && (64'(reg_q) >= 64'(REG_COUNT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            time_q    <= '0;
            reg_q     <= '0;
            pc_q      <= '0;
            addr_q    <= '0;
            is_mem_q  <= 1'b0;
            fmt_q     <= FMT_NONE;
            err_q     <= 4'b0000;
            msg_cnt_q <= '0;
        end else begin
            fmt_q <= FMT_NONE;
            err_q <= 4'b0000;
            if (msg_done) begin
                fmt_q <= is_mem_q ? FMT_MEM : FMT_REG;
                err_q <= err_vec;
                if (msg_cnt_q != {CNT_W{1'b1}}) begin
                    msg_cnt_q <= msg_cnt_q + CNT_W'(1);
                end
            end

            // '^' restarts parsing from any state, discarding the partial message.
            if (char == CH_CARET) begin
                state_q  <= ST_TIME;
                cnt_q    <= '0;
                time_q   <= '0;
                reg_q    <= '0;
                pc_q     <= '0;
                addr_q   <= '0;
                is_mem_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_TIME: begin
                        if (is_dec && time_room) begin
                            time_q <= time_d;
                            cnt_q  <= cnt_inc;
                        end else if ((char == CH_AT) && (cnt_q != '0)) begin
                            state_q <= ST_PC;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_PC: begin
                        if (is_hex && pc_room) begin
                            pc_q  <= pc_d;
                            cnt_q <= cnt_inc;
                        end else if ((char == CH_COLON) && (cnt_q == CW'(PC_DIGITS))) begin
                            state_q <= ST_COLON_SP;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_COLON_SP: begin
                        if (is_space) begin
                            state_q <= ST_COLON_SP;
                        end else if (char == CH_DOLLAR) begin
                            state_q  <= ST_REG;
                            is_mem_q <= 1'b0;
                        end else if (char == CH_STAR) begin
                            state_q  <= ST_ADDR;
                            is_mem_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_REG: begin
                        if (is_dec && reg_room) begin
                            reg_q <= reg_d;
                            cnt_q <= cnt_inc;
                        end else if ((is_space || (char == CH_LT)) && (cnt_q != '0)) begin
                            state_q <= is_space ? ST_PRE_LT : ST_EQ;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_ADDR: begin
                        if (is_hex && addr_room) begin
                            addr_q <= addr_d;
                            cnt_q  <= cnt_inc;
                        end else if ((is_space || (char == CH_LT)) &&
                                     (cnt_q == CW'(ADDR_DIGITS))) begin
                            state_q <= is_space ? ST_PRE_LT : ST_EQ;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_PRE_LT: begin
                        if (is_space) begin
                            state_q <= ST_PRE_LT;
                        end else if (char == CH_LT) begin
                            state_q <= ST_EQ;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_EQ: begin
                        state_q <= (char == CH_EQ) ? ST_PRE_DATA : ST_IDLE;
                    end
                    ST_PRE_DATA: begin
                        if (is_space) begin
                            state_q <= ST_PRE_DATA;
                        end else if (is_hex) begin
                            state_q <= ST_DATA;
                            cnt_q   <= CW'(1);
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        if (is_hex && data_room) begin
                            cnt_q <= cnt_inc;
                        end else if (is_space && (cnt_q == CW'(DATA_DIGITS))) begin
                            state_q <= ST_POST_DATA;
                        end else begin
                            // Covers both a completed '#' and any malformed data.
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_POST_DATA: begin
                        state_q <= is_space ? ST_POST_DATA : ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign format_type = fmt_q;
    assign error_code  = err_q;
    assign msg_count   = msg_cnt_q;

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Bench for cpu_trace_checker: table of trace strings with expected classification,
// a pulse scoreboard keyed on cycle, and hand-written resync/reset/saturation sequences.
module tb_cpu_trace_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  chr;
    logic [15:0] freq;

    logic [1:0]  format_type;
    logic [3:0]  error_code;
    logic [15:0] msg_count;
    logic [1:0]  sat_format_type;
    logic [3:0]  sat_error_code;
    logic [1:0]  sat_msg_count;

    cpu_trace_checker dut (
        .clk         (clk),
        .reset       (reset),
        .char        (chr),
        .freq        (freq),
        .format_type (format_type),
        .error_code  (error_code),
        .msg_count   (msg_count)
    );

    cpu_trace_checker #(.CNT_W(2)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .char        (chr),
        .freq        (freq),
        .format_type (sat_format_type),
        .error_code  (sat_error_code),
        .msg_count   (sat_msg_count)
    );

    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    typedef struct {
        string       msg;
        logic [15:0] freq;
        logic [1:0]  fmt;
        logic [3:0]  err;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] exp_q[$];
    int         cyc_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_count = 0;
    logic [5:0] mon_e;
    int         mon_c;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endfunction

    function automatic void add_vec(input string m, input logic [15:0] f,
                                    input logic [1:0] fm, input logic [3:0] er);
        vec_t v;
        v.msg  = m;
        v.freq = f;
        v.fmt  = fm;
        v.err  = er;
        vecs.push_back(v);
    endfunction

    task automatic send_char(input logic [7:0] c);
        @(negedge clk);
        chr = c;
    endtask

    // Drives a string; when it is a complete valid message the pulse is due one edge after '#'.
    task automatic send_msg(input string s, input logic [1:0] fmt, input logic [3:0] err);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
        end
        if (fmt != 2'd0) begin
            exp_q.push_back({fmt, err});
            cyc_q.push_back(cycle_cnt + 1);
            exp_count++;
        end
    endtask

    task automatic check_count(input string name);
        send_char(8'h20);
        check({name, "_count"}, 32'(msg_count), 32'(exp_count));
        check({name, "_satcount"}, 32'(sat_msg_count), 32'((exp_count > 3) ? 3 : exp_count));
    endtask

    // Scoreboard: every observed pulse must match the head of the queue at its due cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if ((format_type != 2'd0) || (error_code != 4'd0)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {26'd0, format_type, error_code}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_c = cyc_q.pop_front();
                    check("pulse_fields", {26'd0, format_type, error_code}, {26'd0, mon_e});
                    check("pulse_cycle", 32'(cycle_cnt), 32'(mon_c));
                end
            end else if ((cyc_q.size() != 0) && (cyc_q[0] <= cycle_cnt)) begin
                mon_e = exp_q.pop_front();
                mon_c = cyc_q.pop_front();
                check("missed_pulse", {26'd0, format_type, error_code}, {26'd0, mon_e});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        chr   = 8'h00;
        freq  = 16'd2;
        repeat (3) @(negedge clk);
        check("reset_format", 32'(format_type), 32'd0);
        check("reset_error", 32'(error_code), 32'd0);
        check("reset_count", 32'(msg_count), 32'd0);
        reset = 1'b0;

        add_vec("^242@000030f4: $31 <=12345678#",          16'd2, 2'd1, 4'h0);
        add_vec("^338@00003130: *00000088 <= Ffffb528#",   16'd2, 2'd2, 4'h0);
        add_vec("^242@000030f4: $31 <=#",                  16'd2, 2'd0, 4'h0);
        add_vec("^242@000030f4: $31 <=1232158998#",        16'd2, 2'd0, 4'h0);
        add_vec("^242@000030f4: $31 <= ab 12345678#",      16'd2, 2'd0, 4'h0);
        add_vec("^242@000030f4: $31 ab<=12345678#",        16'd2, 2'd0, 4'h0);
        add_vec("^243@000030f4: $31 <=12345678#",          16'd4, 2'd1, 4'h1);
        add_vec("^242@000030f4: $31 <=12345678#",          16'd4, 2'd1, 4'h0);
        add_vec("^242@000030f4: $32 <=12345678#",          16'd2, 2'd1, 4'h8);
        add_vec("^242@00005000: $31 <=12345678#",          16'd2, 2'd1, 4'h2);
        add_vec("^242@000030f4: *00003000 <=12345678#",    16'd2, 2'd2, 4'h4);
        add_vec("^242@000030F6: $0 <= 0badBEEF #",         16'd2, 2'd1, 4'h2);
        add_vec("^242@00004ffc:$0031<=12345678#",          16'd2, 2'd1, 4'h0);
        add_vec("^9999@00003000: *00002ffc<=12345678#",    16'd2, 2'd2, 4'h0);
        add_vec("^1@00002ffc: $1 <=12345678#",             16'd2, 2'd1, 4'h2);
        add_vec("^243@00003004: $32 <=12345678#",          16'd4, 2'd1, 4'h9);
        add_vec("^242@00003004: *00002fff <=12345678#",    16'd6, 2'd2, 4'h5);
        add_vec("^12345@000030f4: $31 <=12345678#",        16'd2, 2'd0, 4'h0);
        add_vec("^242@00030f4: $31 <=12345678#",           16'd2, 2'd0, 4'h0);
        add_vec("^242@000030f4: $00031 <=12345678#",       16'd2, 2'd0, 4'h0);
        add_vec("^242@000030f4: $31 < =12345678#",         16'd2, 2'd0, 4'h0);
        add_vec("^@000030f4: $31 <=12345678#",             16'd2, 2'd0, 4'h0);
        add_vec("^242@000030f4: *0000008 <=12345678#",     16'd2, 2'd0, 4'h0);
        add_vec("^242@000030f4: $31 <=1234567#",           16'd2, 2'd0, 4'h0);
        add_vec("^0@000030f4: $31 <=12345678#",            16'd4, 2'd1, 4'h0);
        add_vec("^6@000030f4: *00000000 <= 12345678 #",    16'd6, 2'd2, 4'h0);
        add_vec("^242#",                                   16'd2, 2'd0, 4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            freq = vecs[i].freq;
            send_msg(vecs[i].msg, vecs[i].fmt, vecs[i].err);
            check_count($sformatf("vec%0d", i));
        end

        // Back-to-back: '^' arrives on the edge that launches the previous pulse.
        freq = 16'd2;
        send_msg("^242@000030f4: $31 <=12345678#", 2'd1, 4'h0);
        send_msg("^338@00003130: *00000088 <= Ffffb528#", 2'd2, 4'h0);
        check_count("b2b");

        // Resync on '^' mid-message.
        send_msg("^24^242@000030f4: $31 <=12345678#", 2'd1, 4'h0);
        check_count("resync_time");
        send_msg("^242@0000^242@000030f4: *00000010 <=12345678#", 2'd2, 4'h0);
        check_count("resync_pc");

        // Only freq at the '#' edge matters.
        freq = 16'd2;
        send_msg("^243@000030f4: $31 <=12345678", 2'd0, 4'h0);
        freq = 16'd4;
        send_msg("#", 2'd1, 4'h1);
        check_count("freq_at_hash_err");
        send_msg("^243@000030f4: $31 <=12345678", 2'd0, 4'h0);
        freq = 16'd2;
        send_msg("#", 2'd1, 4'h0);
        check_count("freq_at_hash_ok");

        // Reset mid-message discards the partial message and clears the count.
        send_msg("^242@0000", 2'd0, 4'h0);
        @(negedge clk);
        reset = 1'b1;
        chr   = 8'h00;
        exp_count = 0;
        @(negedge clk);
        check("midreset_count", 32'(msg_count), 32'd0);
        check("midreset_format", 32'(format_type), 32'd0);
        reset = 1'b0;
        send_msg("^242@000030f4: $31 <=12345678#", 2'd1, 4'h0);
        check_count("after_reset");

        // Four more valid messages: full counter reaches 5, 2-bit counter holds at 3.
        for (int k = 0; k < 4; k++) begin
            send_msg("^242@000030f4: $31 <=12345678#", 2'd1, 4'h0);
            check_count($sformatf("sat%0d", k));
        end

        repeat (4) send_char(8'h00);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
